// File: rtl/bcp_pkg.sv
// Shared types and sizing for the BCP round scheduler.
package bcp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        ISSUE,
        DRAIN,
        POP,
        FLUSH,
        CONFLICT
    } bcp_sched_state_t;

    // Holds counts 0..15, so any MAX_INFLIGHT up to 15 fits.
    localparam int INFLIGHT_CNT_BITS = 4;

endpackage

// File: rtl/bcp_scheduler_inflight_counter.sv
// Up/down count of clauses issued to the eval pipeline but not yet returned.
module inflight_counter
    import bcp_pkg::*;
#(
    parameter int MAX_COUNT = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         clear,
    output logic [INFLIGHT_CNT_BITS-1:0] count,
    output logic                         full,
    output logic                         zero
);

    localparam logic [INFLIGHT_CNT_BITS-1:0] MAX_C = INFLIGHT_CNT_BITS'(MAX_COUNT);

    logic dec_eff;

    // A return with nothing outstanding is spurious and must not underflow.
    assign dec_eff = dec && !zero;
    assign zero    = (count == '0);
    assign full    = (count >= MAX_C);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !dec_eff) begin
            count <= count + 1'b1;
        end else if (!inc && dec_eff) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/bcp_scheduler.sv
// Sequences one BCP round: range lookup, clause issue under an in-flight limit,
// imply-stack walking, and done/conflict reporting to solver control.
module bcp_scheduler
    import bcp_pkg::*;
#(
    parameter int MAX_VARS_BITS     = 8,
    parameter int CLAUSE_TABLE_BITS = 10,
    parameter int MAX_INFLIGHT      = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start_bcp,
    input  logic [MAX_VARS_BITS-1:0]     start_var,
    output logic                         read_var_start_end,
    output logic [MAX_VARS_BITS-1:0]     var_in_vse,
    input  logic [CLAUSE_TABLE_BITS-1:0] start_clause,
    input  logic [CLAUSE_TABLE_BITS-1:0] end_clause,
    output logic                         bcp_en,
    output logic [CLAUSE_TABLE_BITS-1:0] bcp_clause_idx,
    input  logic                         issue_ready,
    input  logic                         res_valid,
    input  logic                         res_conflict,
    input  logic                         empty_imply,
    input  logic [MAX_VARS_BITS-1:0]     var_out_imply,
    output logic                         pop_imply,
    output logic                         reset_bcp,
    output logic                         bcp_busy,
    output logic                         bcp_done,
    output logic                         bcp_conflict
);

    bcp_sched_state_t state, state_nxt;

    logic [CLAUSE_TABLE_BITS-1:0] cur, end_idx;
    logic [CLAUSE_TABLE_BITS:0]   cur_plus_one;
    logic                         last_issue;

    logic [INFLIGHT_CNT_BITS-1:0] inflight;
    logic                         inflight_full, inflight_zero, clear_cnt;
    logic                         transfer, res_accept, conflict_hit, drain_clear;
    logic                         done_set, done_q;

    // One extra bit keeps cur+1 from wrapping onto a small end index.
    assign cur_plus_one = {1'b0, cur} + 1'b1;
    assign last_issue   = (cur_plus_one == {1'b0, end_idx});

    assign res_accept   = res_valid && !inflight_zero;
    assign conflict_hit = res_accept && res_conflict &&
                          (state inside {LOOKUP, ISSUE, DRAIN, POP});
    // The final return counts as drained in the cycle it arrives.
    assign drain_clear  = inflight_zero ||
                          ((inflight == INFLIGHT_CNT_BITS'(1)) && res_accept);

    assign bcp_busy = (state != IDLE);
    assign bcp_done = done_q;

    inflight_counter #(
        .MAX_COUNT (MAX_INFLIGHT)
    ) u_inflight (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (transfer),
        .dec     (res_valid),
        .clear   (clear_cnt),
        .count   (inflight),
        .full    (inflight_full),
        .zero    (inflight_zero)
    );

    // NOTE: every output is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt          = state;
        read_var_start_end = 1'b0;
        var_in_vse         = '0;
        bcp_en             = 1'b0;
        bcp_clause_idx     = '0;
        transfer           = 1'b0;
        pop_imply          = 1'b0;
        reset_bcp          = 1'b0;
        bcp_conflict       = 1'b0;
        clear_cnt          = 1'b0;
        done_set           = 1'b0;

        case (state)
            IDLE: begin
                if (start_bcp) begin
                    read_var_start_end = 1'b1;
                    var_in_vse         = start_var;
                    state_nxt          = LOOKUP;
                end
            end
            LOOKUP: begin
                if (conflict_hit)                     state_nxt = FLUSH;
                else if (start_clause == end_clause)  state_nxt = DRAIN;
                else                                  state_nxt = ISSUE;
            end
            ISSUE: begin
                bcp_en         = !inflight_full && !conflict_hit;
                bcp_clause_idx = cur;
                transfer       = bcp_en && issue_ready;
                if (conflict_hit)                 state_nxt = FLUSH;
                else if (transfer && last_issue)  state_nxt = DRAIN;
            end
            DRAIN: begin
                if (conflict_hit) begin
                    state_nxt = FLUSH;
                end else if (drain_clear) begin
                    if (empty_imply) begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = POP;
                    end
                end
            end
            POP: begin
                pop_imply          = 1'b1;
                read_var_start_end = 1'b1;
                var_in_vse         = var_out_imply;
                state_nxt          = conflict_hit ? FLUSH : LOOKUP;
            end
            FLUSH: begin
                reset_bcp = 1'b1;
                clear_cnt = 1'b1;
                state_nxt = CONFLICT;
            end
            CONFLICT: begin
                bcp_conflict = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cur     <= '0;
            end_idx <= '0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_set;
            if (state == LOOKUP) begin
                cur     <= start_clause;
                end_idx <= end_clause;
            end else if (transfer) begin
                cur <= cur + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bcp_scheduler.sv
// Self-checking bench for bcp_scheduler: table-driven rounds with an issue
// scoreboard, plus hand-written conflict, in-flight limit and reset sequences.
module tb_bcp_scheduler;

    localparam int VB = 8;
    localparam int CB = 10;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_bcp = 1'b0;
    logic [VB-1:0] start_var = '0;
    logic [CB-1:0] start_clause = '0;
    logic [CB-1:0] end_clause = '0;
    logic          issue_ready = 1'b1;
    logic          res_valid = 1'b0;
    logic          res_conflict = 1'b0;
    logic          empty_imply = 1'b1;
    logic [VB-1:0] var_out_imply = '0;

    logic          read_var_start_end, bcp_en, pop_imply, reset_bcp, bcp_busy, bcp_done, bcp_conflict;
    logic [VB-1:0] var_in_vse;
    logic [CB-1:0] bcp_clause_idx;

    logic          b_read, b_en, b_pop, b_reset_bcp, b_busy, b_done, b_conflict;
    logic [VB-1:0] b_var_in_vse;
    logic [CB-1:0] b_idx;

    always #5 clock = ~clock;

    bcp_scheduler #(.MAX_VARS_BITS(VB), .CLAUSE_TABLE_BITS(CB), .MAX_INFLIGHT(8)) dut (
        .clock(clock), .reset_n(reset_n), .start_bcp(start_bcp), .start_var(start_var),
        .read_var_start_end(read_var_start_end), .var_in_vse(var_in_vse),
        .start_clause(start_clause), .end_clause(end_clause),
        .bcp_en(bcp_en), .bcp_clause_idx(bcp_clause_idx), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_conflict(res_conflict),
        .empty_imply(empty_imply), .var_out_imply(var_out_imply),
        .pop_imply(pop_imply), .reset_bcp(reset_bcp), .bcp_busy(bcp_busy),
        .bcp_done(bcp_done), .bcp_conflict(bcp_conflict)
    );

    bcp_scheduler #(.MAX_VARS_BITS(VB), .CLAUSE_TABLE_BITS(CB), .MAX_INFLIGHT(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .start_bcp(start_bcp), .start_var(start_var),
        .read_var_start_end(b_read), .var_in_vse(b_var_in_vse),
        .start_clause(start_clause), .end_clause(end_clause),
        .bcp_en(b_en), .bcp_clause_idx(b_idx), .issue_ready(issue_ready),
        .res_valid(res_valid), .res_conflict(res_conflict),
        .empty_imply(empty_imply), .var_out_imply(var_out_imply),
        .pop_imply(b_pop), .reset_bcp(b_reset_bcp), .bcp_busy(b_busy),
        .bcp_done(b_done), .bcp_conflict(b_conflict)
    );

    // ---------------- models and scoreboard state ----------------
    typedef struct { int due; int idx; } ret_t;
    typedef struct {
        logic [VB-1:0] sv;
        int            n_imp;
        logic [VB-1:0] iv0;
        logic [VB-1:0] iv1;
        int            exp_issues;
        int            exp_pops;
    } vec_t;
    typedef struct { bit res; bit rdy; bit en; int idx; } m2_t;

    logic [CB-1:0] st_tbl [256];
    logic [CB-1:0] en_tbl [256];
    logic [VB-1:0] imply_q [$];
    ret_t          pend [$];
    int            exp_q [$];

    int  cyc = 0;
    bit  sb_on = 1'b1;
    bit  auto_ret = 1'b1;
    int  ret_delay = 3;
    int  conf_idx = -1;

    bit            rd_f, pop_f, rb_f, xf_f;
    logic [VB-1:0] rd_var;
    int            xf_idx, xf_cyc;

    int done_cnt, conf_cnt, pop_cnt, rb_cnt, xfer_cnt, first_en_cyc, done_cyc;
    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples DUT outputs mid-cycle and pops the issue scoreboard.
    always @(negedge clock) begin
        rd_f   = read_var_start_end;
        rd_var = var_in_vse;
        pop_f  = pop_imply;
        rb_f   = reset_bcp;
        xf_f   = bcp_en && issue_ready;
        xf_idx = int'(bcp_clause_idx);
        xf_cyc = cyc;
        if (bcp_en && first_en_cyc < 0) first_en_cyc = cyc;
        if (bcp_done) begin done_cnt++; done_cyc = cyc; end
        if (bcp_conflict) conf_cnt++;
        if (pop_imply) pop_cnt++;
        if (reset_bcp) rb_cnt++;
        if (reset_n) check("done_and_conflict_exclusive", {bcp_done, bcp_conflict} == 2'b11, 0);
        if (xf_f) begin
            xfer_cnt++;
            if (sb_on) begin
                if (exp_q.size() > 0) check("issue_idx", xf_idx, exp_q.pop_front());
                else                  check("unexpected_issue", xf_idx, -1);
            end
        end
    end

    // Responders: table read, imply stack and eval pipeline, driven just after the edge.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (!reset_n) begin
            pend.delete();
            res_valid    = 1'b0;
            res_conflict = 1'b0;
        end else begin
            if (rb_f) begin
                pend.delete();
                imply_q.delete();
            end
            if (rd_f) begin
                start_clause = st_tbl[rd_var];
                end_clause   = en_tbl[rd_var];
            end
            if (pop_f && imply_q.size() > 0) void'(imply_q.pop_front());
            if (xf_f) pend.push_back('{xf_cyc + ret_delay, xf_idx});
            if (auto_ret) begin
                res_valid    = 1'b0;
                res_conflict = 1'b0;
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    res_valid    = 1'b1;
                    res_conflict = (pend[0].idx == conf_idx);
                    void'(pend.pop_front());
                end
            end
        end
        empty_imply   = (imply_q.size() == 0);
        var_out_imply = (imply_q.size() == 0) ? '0 : imply_q[0];
    end

    // ---------------- helpers ----------------
    task automatic at_cycle(input int c);
        do @(negedge clock); while (cyc < c);
        #1;
    endtask

    task automatic drive_at(input int c);
        while (cyc < c) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic clr_mon();
        done_cnt = 0; conf_cnt = 0; pop_cnt = 0; rb_cnt = 0; xfer_cnt = 0;
        first_en_cyc = -1; done_cyc = -1;
    endtask

    task automatic push_range(input logic [VB-1:0] v);
        for (int i = int'(st_tbl[v]); i < int'(en_tbl[v]); i++) exp_q.push_back(i);
    endtask

    task automatic start_round(input logic [VB-1:0] v, output int s);
        @(posedge clock);
        #1;
        s         = cyc;
        start_var = v;
        start_bcp = 1'b1;
        @(posedge clock);
        #1;
        start_bcp = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (done_cnt == 0 && conf_cnt == 0 && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        check("round_finished", (done_cnt + conf_cnt) > 0, 1);
    endtask

    task automatic run_vec(input vec_t v, output int s);
        clr_mon();
        exp_q.delete();
        imply_q.delete();
        push_range(v.sv);
        if (v.n_imp > 0) begin imply_q.push_back(v.iv0); push_range(v.iv0); end
        if (v.n_imp > 1) begin imply_q.push_back(v.iv1); push_range(v.iv1); end
        start_round(v.sv, s);
        wait_end(300);
        at_cycle(cyc + 1);
        check("done_pulses", done_cnt, 1);
        check("conflict_pulses", conf_cnt, 0);
        check("issue_count", xfer_cnt, v.exp_issues);
        check("pop_count", pop_cnt, v.exp_pops);
        check("scoreboard_left", exp_q.size(), 0);
        check("busy_after_done", bcp_busy, 0);
    endtask

    task automatic reset_all();
        drive_at(cyc + 1);
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        res_valid    = 1'b0;
        res_conflict = 1'b0;
        issue_ready  = 1'b1;
        auto_ret     = 1'b1;
        sb_on        = 1'b1;
        ret_delay    = 3;
        conf_idx     = -1;
        exp_q.delete();
        imply_q.delete();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 20000", cyc);
        $fatal(1);
    end

    // ---------------- test sequence ----------------
    initial begin
        vec_t     vecs [6];
        m2_t      m2 [9];
        logic [4:0] cf_exp [5];
        int       s;

        for (int i = 0; i < 256; i++) begin st_tbl[i] = '0; en_tbl[i] = '0; end
        st_tbl[101] = 10'd0;    en_tbl[101] = 10'd2;
        st_tbl[7]   = 10'd3;    en_tbl[7]   = 10'd6;
        st_tbl[55]  = 10'd5;    en_tbl[55]  = 10'd5;
        st_tbl[20]  = 10'd0;    en_tbl[20]  = 10'd6;
        st_tbl[31]  = 10'd10;   en_tbl[31]  = 10'd20;
        st_tbl[40]  = 10'd1020; en_tbl[40]  = 10'd1023;

        vecs[0] = '{8'd101, 0, 8'd0,  8'd0,   2, 0};
        vecs[1] = '{8'd55,  0, 8'd0,  8'd0,   0, 0};
        vecs[2] = '{8'd101, 1, 8'd7,  8'd0,   5, 1};
        vecs[3] = '{8'd55,  2, 8'd7,  8'd101, 5, 2};
        vecs[4] = '{8'd40,  0, 8'd0,  8'd0,   3, 0};
        vecs[5] = '{8'd20,  1, 8'd55, 8'd0,   6, 1};

        // {bcp_en, reset_bcp, bcp_conflict, bcp_busy, bcp_done} for cycles S+5..S+9
        cf_exp[0] = 5'b10010;
        cf_exp[1] = 5'b00010;
        cf_exp[2] = 5'b01010;
        cf_exp[3] = 5'b00110;
        cf_exp[4] = 5'b00000;

        // MAX_INFLIGHT=2 instance, cycles S+2..S+10: drive res_valid/issue_ready, expect bcp_en/idx
        m2[0] = '{1'b0, 1'b1, 1'b1, 0};
        m2[1] = '{1'b0, 1'b1, 1'b1, 1};
        m2[2] = '{1'b0, 1'b1, 1'b0, 0};
        m2[3] = '{1'b0, 1'b1, 1'b0, 0};
        m2[4] = '{1'b1, 1'b1, 1'b0, 0};
        m2[5] = '{1'b0, 1'b0, 1'b1, 2};
        m2[6] = '{1'b0, 1'b0, 1'b1, 2};
        m2[7] = '{1'b0, 1'b1, 1'b1, 2};
        m2[8] = '{1'b0, 1'b1, 1'b0, 0};

        clr_mon();
        repeat (3) @(posedge clock);
        #2;
        check("reset_outputs",
              {read_var_start_end, var_in_vse, bcp_en, bcp_clause_idx, pop_imply,
               reset_bcp, bcp_busy, bcp_done, bcp_conflict}, 0);
        reset_n = 1'b1;

        // Table-driven rounds, with latency checks on the simple ones.
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], s);
            if (i == 0) begin
                check("first_en_latency", first_en_cyc - s, 2);
                check("done_latency_range2", done_cyc - s, 7);
            end
            if (i == 1) begin
                check("done_latency_empty", done_cyc - s, 3);
                check("no_issue_empty", first_en_cyc, -1);
            end
        end

        // Conflict on the first of four in-flight clauses.
        clr_mon();
        exp_q.delete();
        for (int i = 10; i < 14; i++) exp_q.push_back(i);
        ret_delay = 4;
        conf_idx  = 10;
        start_round(8'd31, s);
        for (int k = 0; k < 5; k++) begin
            at_cycle(s + 5 + k);
            check($sformatf("conflict_seq_c%0d", 5 + k),
                  {bcp_en, reset_bcp, bcp_conflict, bcp_busy, bcp_done}, cf_exp[k]);
        end
        at_cycle(cyc + 4);
        check("conflict_no_done", done_cnt, 0);
        check("conflict_pulses", conf_cnt, 1);
        check("reset_bcp_pulses", rb_cnt, 1);
        check("conflict_issue_count", xfer_cnt, 4);
        check("conflict_scoreboard_left", exp_q.size(), 0);
        ret_delay = 3;
        conf_idx  = -1;

        // In-flight limit and issue_ready stall on the MAX_INFLIGHT=2 instance.
        sb_on    = 1'b0;
        auto_ret = 1'b0;
        start_round(8'd20, s);
        for (int k = 0; k < 9; k++) begin
            drive_at(s + 2 + k);
            res_valid   = m2[k].res;
            issue_ready = m2[k].rdy;
            at_cycle(s + 2 + k);
            check($sformatf("limit_en_c%0d", 2 + k), b_en, m2[k].en);
            if (m2[k].en) check($sformatf("limit_idx_c%0d", 2 + k), b_idx, m2[k].idx);
        end
        reset_all();

        // Asynchronous reset in the middle of ISSUE, then a clean round.
        clr_mon();
        exp_q.delete();
        push_range(8'd20);
        start_round(8'd20, s);
        drive_at(s + 3);
        check("busy_before_reset", bcp_busy, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {read_var_start_end, var_in_vse, bcp_en, bcp_clause_idx, pop_imply,
               reset_bcp, bcp_busy, bcp_done, bcp_conflict}, 0);
        repeat (2) @(posedge clock);
        #2;
        exp_q.delete();
        reset_n = 1'b1;
        at_cycle(cyc + 2);
        check("reset_no_done", done_cnt, 0);
        check("reset_no_conflict", conf_cnt, 0);
        run_vec(vecs[0], s);
        check("post_reset_first_en", first_en_cyc - s, 2);
        check("post_reset_done_latency", done_cyc - s, 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
